// File: rtl/steer_quad_pkg.sv
// steer_quad_pkg: shared types, Gray phase helpers and parameter legality check
// for the multi-channel steering quadrature encoder.
package steer_quad_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN_R = 2'd1, RUN_L = 2'd2} steer_dir_t;

    // Right-turn order is 00 -> 01 -> 11 -> 10 -> 00 on {A,B}.
    function automatic logic [1:0] gray_next(input logic [1:0] p);
        return p == 2'b00 ? 2'b01 : p == 2'b01 ? 2'b11 : p == 2'b11 ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] gray_prev(input logic [1:0] p);
        return p == 2'b00 ? 2'b10 : p == 2'b10 ? 2'b11 : p == 2'b11 ? 2'b01 : 2'b00;
    endfunction

    function automatic bit params_ok(input int ch, input int dw, input int slow,
                                     input int fast, input int mn, input int dec);
        return ch >= 1 && ch <= 4 && dw >= 1 && dw < 31 &&
               slow < (1 << dw) && fast < (1 << dw) &&
               mn >= 1 && mn <= slow && mn <= fast && dec >= 0;
    endfunction

endpackage

// File: rtl/steer_quad_multi_if.sv
// steer_quad_multi_if: request inputs and quadrature/strobe outputs of the
// steering encoder, sized by channel count.
interface steer_quad_multi_if #(parameter int CHANNELS = 2) ();
    logic                  rate_sel;
    logic [CHANNELS-1:0]   left;
    logic [CHANNELS-1:0]   right;
    logic [2*CHANNELS-1:0] steer;
    logic [CHANNELS-1:0]   step;
    modport master (output rate_sel, left, right, input steer, step);
    modport slave  (input rate_sel, left, right, output steer, step);
endinterface

// File: rtl/steer_quad_chan.sv
// steer_quad_chan: one steering channel -- input register, direction FSM,
// accelerating step-period counter and Gray phase output.
module steer_quad_chan
    import steer_quad_pkg::*;
#(
    parameter int DIV_W         = 16,
    parameter int BASE_DIV_SLOW = 22500,
    parameter int BASE_DIV_FAST = 11250,
    parameter int MIN_DIV       = 5625,
    parameter int ACCEL_DEC     = 2048
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       rate_sel,
    input  logic       left,
    input  logic       right,
    output logic [1:0] steer,
    output logic       step
);
    logic             left_q, right_q;
    steer_dir_t       state_q, state_d, dir;
    logic [DIV_W-1:0] cnt_q, cnt_d, period_q, period_d;
    logic [DIV_W-1:0] base, cnt_e, period_e;
    logic [1:0]       phase_q, phase_d;
    logic             step_q, step_d, fire;
    int               sub;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            left_q   <= 1'b0;
            right_q  <= 1'b0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= DIV_W'(BASE_DIV_SLOW);
            phase_q  <= 2'b00;
            step_q   <= 1'b0;
        end else begin
            left_q   <= left;
            right_q  <= right;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            phase_q  <= phase_d;
            step_q   <= step_d;
        end
    end

    always_comb begin
        dir     = (right_q && !left_q) ? RUN_R : (left_q && !right_q) ? RUN_L : IDLE;
        state_d = dir;
    end

    // A press or reversal restarts the run within the same cycle so the first step lands immediately.
    always_comb begin
        base     = rate_sel ? DIV_W'(BASE_DIV_FAST) : DIV_W'(BASE_DIV_SLOW);
        cnt_e    = (state_q != dir) ? '0 : cnt_q;
        period_e = (state_q != dir) ? base : period_q;
        fire     = (dir != IDLE) && (cnt_e == '0);
        sub      = int'(period_e) - ACCEL_DEC;
        cnt_d    = (dir == IDLE) ? '0 : fire ? period_e - 1'b1 : cnt_e - 1'b1;
        period_d = (dir == IDLE) ? base
                 : !fire ? period_e
                 : (sub > MIN_DIV) ? DIV_W'(sub) : DIV_W'(MIN_DIV);
        phase_d  = !fire ? phase_q : (dir == RUN_R) ? gray_next(phase_q) : gray_prev(phase_q);
        step_d   = fire;
    end

    assign steer = phase_q;
    assign step  = step_q;

endmodule

// File: rtl/steer_quad_multi.sv
// steer_quad_multi: CHANNELS independent joystick-to-quadrature steering
// encoders; channel i drives steer[2i+1]=A, steer[2i]=B and step[i].
module steer_quad_multi
    import steer_quad_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int DIV_W         = 16,
    parameter int BASE_DIV_SLOW = 22500,
    parameter int BASE_DIV_FAST = 11250,
    parameter int MIN_DIV       = 5625,
    parameter int ACCEL_DEC     = 2048
) (
    input logic                CLK,
    input logic                reset,
    steer_quad_multi_if.slave  bus
);
    logic [2*CHANNELS-1:0] steer_w;
    logic [CHANNELS-1:0]   step_w;

    if (!params_ok(CHANNELS, DIV_W, BASE_DIV_SLOW, BASE_DIV_FAST, MIN_DIV, ACCEL_DEC)) begin : g_bad
        $error("steer_quad_multi: illegal parameter set");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        steer_quad_chan #(
            .DIV_W        (DIV_W),
            .BASE_DIV_SLOW(BASE_DIV_SLOW),
            .BASE_DIV_FAST(BASE_DIV_FAST),
            .MIN_DIV      (MIN_DIV),
            .ACCEL_DEC    (ACCEL_DEC)
        ) u_chan (
            .CLK     (CLK),
            .reset   (reset),
            .rate_sel(bus.rate_sel),
            .left    (bus.left[i]),
            .right   (bus.right[i]),
            .steer   (steer_w[2*i+1 -: 2]),
            .step    (step_w[i])
        );
    end

    assign bus.steer = steer_w;
    assign bus.step  = step_w;

endmodule

// File: tb/tb_steer_quad_multi.sv
// tb_steer_quad_multi: scoreboard bench; a step-schedule model predicts each
// cycle's steer/step and a monitor compares them after every clock edge.
module tb_steer_quad_multi;
    localparam int CH = 2, SLOW = 8, FAST = 4, MIN = 4, DEC = 2;

    logic CLK = 1'b0;
    logic reset = 1'b0;

    steer_quad_multi_if #(.CHANNELS(CH)) bus ();

    steer_quad_multi #(
        .CHANNELS(CH), .DIV_W(16), .BASE_DIV_SLOW(SLOW),
        .BASE_DIV_FAST(FAST), .MIN_DIV(MIN), .ACCEL_DEC(DEC)
    ) dut (
        .CLK  (CLK),
        .reset(reset),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2*CH-1:0] steer;
        logic [CH-1:0]   step;
    } exp_t;

    exp_t q[$];
    exp_t got, want;
    int   errors = 0, checks = 0;
    bit   mon_on = 0;

    // Model: a run is a list of step times; gaps shrink by DEC from the base down to MIN.
    int   pos[CH], nxt[CH], nsteps[CH], runbase[CH], last[CH], edge_n;
    bit   lq[CH], rq[CH];
    logic [1:0] gray_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    function automatic logic [1:0] ph(input int p);
        return gray_tab[((p % 4) + 4) % 4];
    endfunction

    task automatic model_edge(input bit rs, input bit rate, input logic [CH-1:0] l, input logic [CH-1:0] r);
        exp_t e;
        int d, gap;
        e = '0;
        edge_n++;
        for (int c = 0; c < CH; c++) begin
            if (rs) begin
                pos[c] = 0; last[c] = 0; lq[c] = 0; rq[c] = 0;
            end else begin
                d = (rq[c] && !lq[c]) ? 1 : (lq[c] && !rq[c]) ? -1 : 0;
                if (d != 0) begin
                    if (d != last[c]) begin
                        nxt[c] = edge_n; nsteps[c] = 0; runbase[c] = rate ? FAST : SLOW;
                    end
                    if (edge_n == nxt[c]) begin
                        pos[c] += d;
                        e.step[c] = 1'b1;
                        gap = runbase[c] - nsteps[c] * DEC;
                        nxt[c] = edge_n + (gap > MIN ? gap : MIN);
                        nsteps[c]++;
                    end
                end
                last[c] = d;
                lq[c] = l[c]; rq[c] = r[c];
            end
            e.steer[2*c +: 2] = ph(pos[c]);
        end
        q.push_back(e);
    endtask

    task automatic cyc(input bit rs, input bit rate, input logic [CH-1:0] l, input logic [CH-1:0] r);
        @(negedge CLK);
        reset = rs;
        bus.rate_sel = rate;
        bus.left = l;
        bus.right = r;
        mon_on = 1;
        model_edge(rs, rate, l, r);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (bus.steer !== '0 || bus.step !== '0) begin
            errors++;
            $display("FAIL %s: steer=%b step=%b, required steer=0 step=0", name, bus.steer, bus.step);
        end
    endtask

    always @(posedge CLK) begin
        #1;
        if (mon_on) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: output at t=%0t with no expected entry", $time);
            end else begin
                want = q.pop_front();
                got = '{steer: bus.steer, step: bus.step};
                if (got !== want) begin
                    errors++;
                    $display("FAIL cycle t=%0t: steer=%b step=%b, required steer=%b step=%b",
                             $time, got.steer, got.step, want.steer, want.step);
                end
            end
        end
    end

    initial begin
        bus.rate_sel = 0; bus.left = '0; bus.right = '0;
        edge_n = 0;
        for (int c = 0; c < CH; c++) begin
            pos[c] = 0; nxt[c] = 0; nsteps[c] = 0; runbase[c] = SLOW; last[c] = 0; lq[c] = 0; rq[c] = 0;
        end
        #1 reset = 1;
        #1 check_zero("reset_state");
        repeat (2) cyc(1, 0, 2'b00, 2'b00);
        // Right on channel 0: steps at 1,9,15,19,23.
        repeat (26) cyc(0, 0, 2'b00, 2'b01);
        repeat (4) cyc(0, 0, 2'b00, 2'b00);
        // Left on channel 1, release, re-press.
        repeat (20) cyc(0, 0, 2'b10, 2'b00);
        repeat (6) cyc(0, 0, 2'b00, 2'b00);
        repeat (12) cyc(0, 0, 2'b10, 2'b00);
        repeat (3) cyc(0, 0, 2'b00, 2'b00);
        // Both directions on channel 0.
        repeat (30) cyc(0, 0, 2'b01, 2'b01);
        // Reversal: right then left.
        repeat (12) cyc(0, 0, 2'b00, 2'b01);
        repeat (14) cyc(0, 0, 2'b01, 2'b00);
        repeat (3) cyc(0, 0, 2'b00, 2'b00);
        // Fast rate at press, rate_sel toggled mid-run, both channels together.
        repeat (3) cyc(0, 1, 2'b00, 2'b11);
        for (int k = 0; k < 20; k++) cyc(0, k[0], 2'b00, 2'b11);
        // Slow press while rate toggles afterwards, then a mid-cycle asynchronous reset.
        repeat (2) cyc(0, 0, 2'b00, 2'b00);
        repeat (6) cyc(0, 0, 2'b00, 2'b01);
        for (int k = 0; k < 6; k++) cyc(0, k[1], 2'b00, 2'b01);
        @(posedge CLK);
        #3 reset = 1;
        #1 check_zero("async_reset");
        repeat (2) cyc(1, 0, 2'b00, 2'b01);
        repeat (12) cyc(0, 0, 2'b00, 2'b01);
        // Randomised traffic with sticky inputs so runs last long enough to accelerate.
        begin
            logic [CH-1:0] l, r;
            bit rate;
            l = '0; r = '0; rate = 0;
            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(0, 9) == 0) l = CH'($urandom);
                if ($urandom_range(0, 9) == 0) r = CH'($urandom);
                if ($urandom_range(0, 3) == 0) rate = 1'($urandom);
                cyc(0, rate, l, r);
            end
        end
        repeat (3) cyc(0, 0, 2'b00, 2'b00);
        @(posedge CLK);
        #2 mon_on = 0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
